// File: rtl/riscv_axi_pkg.sv
// Shared AXI response codes and error-FSM state types for the DRAM window bridge.
package riscv_axi_pkg;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespDecerr = 2'b11;

   typedef enum logic [1:0] {RdIdle, RdDrain, RdResp} rd_state_e;
   typedef enum logic [1:0] {WrIdle, WrDrain, WrSink, WrBresp} wr_state_e;

endpackage

// File: rtl/riscv_axi_outstanding_ctr.sv
// Saturating in-flight transaction counter with full/empty flags.
module riscv_axi_outstanding_ctr #(
   parameter int unsigned C_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic empty
);

   localparam int unsigned CW = $clog2(C_LIMIT + 1);

   logic [CW-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (inc && !dec && !full) begin
         count_q <= count_q + 1'b1;
      end else if (dec && !inc && !empty) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign full  = (count_q == CW'(C_LIMIT));
   assign empty = (count_q == '0);

endmodule

// File: rtl/riscv_axi_dram_window.sv
// AXI4 address-window remapper with outstanding limits; out-of-window requests get
// DECERR responses when RISCV_WINDOW_ERR_EN is defined, otherwise every address is remapped.
module riscv_axi_dram_window
   import riscv_axi_pkg::*;
#(
   parameter int unsigned             C_ID_WIDTH        = 6,
   parameter int unsigned             C_ADDR_WIDTH      = 32,
   parameter int unsigned             C_DATA_WIDTH      = 64,
   parameter logic [C_ADDR_WIDTH-1:0] C_DRAM_BASE       = 32'h1000_0000,
   parameter int unsigned             C_DRAM_BITS       = 28,
   parameter logic [C_ADDR_WIDTH-1:0] C_OUT_BASE        = 32'h3000_0000,
   parameter int unsigned             C_MAX_OUTSTANDING = 4
) (
   input  logic                      m_axi_aclk,
   input  logic                      m_axi_aresetn,
   // core side
   input  logic [C_ID_WIDTH-1:0]     s_axi_awid,
   input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awlock,
   input  logic [3:0]                s_axi_awcache,
   input  logic [2:0]                s_axi_awprot,
   input  logic [3:0]                s_axi_awqos,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [C_ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [C_ID_WIDTH-1:0]     s_axi_arid,
   input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arlock,
   input  logic [3:0]                s_axi_arcache,
   input  logic [2:0]                s_axi_arprot,
   input  logic [3:0]                s_axi_arqos,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [C_ID_WIDTH-1:0]     s_axi_rid,
   output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   // memory side
   output logic [C_ID_WIDTH-1:0]     m_axi_awid,
   output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic                      m_axi_awlock,
   output logic [3:0]                m_axi_awcache,
   output logic [2:0]                m_axi_awprot,
   output logic [3:0]                m_axi_awqos,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                      m_axi_wlast,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [C_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [C_ID_WIDTH-1:0]     m_axi_arid,
   output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [C_ID_WIDTH-1:0]     m_axi_rid,
   input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [7:0]                err_count
);

   localparam logic [C_ADDR_WIDTH-1:0] LowMask =
      C_ADDR_WIDTH'((64'd1 << C_DRAM_BITS) - 64'd1);

   function automatic logic [C_ADDR_WIDTH-1:0] remap(input logic [C_ADDR_WIDTH-1:0] a);
      return (C_OUT_BASE & ~LowMask) | (a & LowMask);
   endfunction

   // Valids/readies are forced low combinationally for the whole time reset is held.
   logic run;
   assign run = m_axi_aresetn;

   logic rd_full, rd_empty, wr_full, wr_empty;

   riscv_axi_outstanding_ctr #(
      .C_LIMIT (C_MAX_OUTSTANDING)
   ) u_rd_ctr (
      .clk   (m_axi_aclk),
      .rst_n (m_axi_aresetn),
      .inc   (m_axi_arvalid & m_axi_arready),
      .dec   (m_axi_rvalid & m_axi_rready & m_axi_rlast),
      .full  (rd_full),
      .empty (rd_empty)
   );

   riscv_axi_outstanding_ctr #(
      .C_LIMIT (C_MAX_OUTSTANDING)
   ) u_wr_ctr (
      .clk   (m_axi_aclk),
      .rst_n (m_axi_aresetn),
      .inc   (m_axi_awvalid & m_axi_awready),
      .dec   (m_axi_bvalid & m_axi_bready),
      .full  (wr_full),
      .empty (wr_empty)
   );

   // Address channels: remap plus field passthrough with no added latency.
   assign m_axi_awid    = s_axi_awid;
   assign m_axi_awaddr  = remap(s_axi_awaddr);
   assign m_axi_awlen   = s_axi_awlen;
   assign m_axi_awsize  = s_axi_awsize;
   assign m_axi_awburst = s_axi_awburst;
   assign m_axi_awlock  = s_axi_awlock;
   assign m_axi_awcache = s_axi_awcache;
   assign m_axi_awprot  = s_axi_awprot;
   assign m_axi_awqos   = s_axi_awqos;
   assign m_axi_arid    = s_axi_arid;
   assign m_axi_araddr  = remap(s_axi_araddr);
   assign m_axi_arlen   = s_axi_arlen;
   assign m_axi_arsize  = s_axi_arsize;
   assign m_axi_arburst = s_axi_arburst;
   assign m_axi_arlock  = s_axi_arlock;
   assign m_axi_arcache = s_axi_arcache;
   assign m_axi_arprot  = s_axi_arprot;
   assign m_axi_arqos   = s_axi_arqos;
   assign m_axi_wdata   = s_axi_wdata;
   assign m_axi_wstrb   = s_axi_wstrb;
   assign m_axi_wlast   = s_axi_wlast;

`ifdef RISCV_WINDOW_ERR_EN

   localparam int unsigned OwedW = $clog2(C_MAX_OUTSTANDING + 1);

   rd_state_e             rd_state_q;
   wr_state_e             wr_state_q;
   logic [C_ID_WIDTH-1:0] rd_id_q, wr_id_q;
   logic [7:0]            rd_len_q, rd_beat_q;
   logic                  w_sink_q;
   logic [OwedW-1:0]      w_owed_q;
   logic [7:0]            err_q;
   logic                  ar_in_win, aw_in_win, ar_reject, aw_reject;
   logic                  rd_idle, wr_idle, rd_pass, wr_pass, aw_fwd, w_fwd_last;
   logic [8:0]            err_sum;

   assign ar_in_win = ((s_axi_araddr ^ C_DRAM_BASE) & ~LowMask) == '0;
   assign aw_in_win = ((s_axi_awaddr ^ C_DRAM_BASE) & ~LowMask) == '0;
   assign rd_idle   = (rd_state_q == RdIdle);
   assign wr_idle   = (wr_state_q == WrIdle);
   assign rd_pass   = (rd_state_q != RdResp);
   assign wr_pass   = (wr_state_q != WrBresp);

   assign ar_reject = run & rd_idle & s_axi_arvalid & ~ar_in_win;
   // A rejected AW must not flip the W route while an earlier burst's data is still owed.
   assign aw_reject = run & wr_idle & s_axi_awvalid & ~aw_in_win & (w_owed_q == '0);

   assign m_axi_arvalid = run & rd_idle & s_axi_arvalid & ar_in_win & ~rd_full;
   assign s_axi_arready = run & rd_idle & (ar_in_win ? (m_axi_arready & ~rd_full) : 1'b1);
   assign m_axi_awvalid = run & wr_idle & s_axi_awvalid & aw_in_win & ~wr_full;
   assign s_axi_awready = run & wr_idle &
                          (aw_in_win ? (m_axi_awready & ~wr_full) : (w_owed_q == '0));

   assign m_axi_wvalid = run & s_axi_wvalid & ~w_sink_q;
   assign s_axi_wready = run & (w_sink_q ? (wr_state_q == WrSink) : m_axi_wready);

   assign s_axi_rvalid = run & (rd_pass ? m_axi_rvalid : 1'b1);
   assign s_axi_rid    = rd_pass ? m_axi_rid : rd_id_q;
   assign s_axi_rdata  = rd_pass ? m_axi_rdata : '0;
   assign s_axi_rresp  = rd_pass ? m_axi_rresp : RespDecerr;
   assign s_axi_rlast  = rd_pass ? m_axi_rlast : (rd_beat_q == rd_len_q);
   assign m_axi_rready = run & rd_pass & s_axi_rready;

   assign s_axi_bvalid = run & (wr_pass ? m_axi_bvalid : 1'b1);
   assign s_axi_bid    = wr_pass ? m_axi_bid : wr_id_q;
   assign s_axi_bresp  = wr_pass ? m_axi_bresp : RespDecerr;
   assign m_axi_bready = run & wr_pass & s_axi_bready;

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         rd_state_q <= RdIdle;
         rd_id_q    <= '0;
         rd_len_q   <= '0;
         rd_beat_q  <= '0;
      end else begin
         unique case (rd_state_q)
            RdIdle: if (ar_reject) begin
               rd_id_q    <= s_axi_arid;
               rd_len_q   <= s_axi_arlen;
               rd_beat_q  <= '0;
               rd_state_q <= RdDrain;
            end
            RdDrain: if (rd_empty) rd_state_q <= RdResp;
            RdResp: if (s_axi_rready) begin
               if (rd_beat_q == rd_len_q) rd_state_q <= RdIdle;
               else                       rd_beat_q  <= rd_beat_q + 8'd1;
            end
            default: rd_state_q <= RdIdle;
         endcase
      end
   end

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         wr_state_q <= WrIdle;
         wr_id_q    <= '0;
         w_sink_q   <= 1'b0;
      end else begin
         unique case (wr_state_q)
            WrIdle: if (aw_reject) begin
               wr_id_q    <= s_axi_awid;
               w_sink_q   <= 1'b1;
               wr_state_q <= WrDrain;
            end else if (m_axi_awvalid && m_axi_awready) begin
               w_sink_q <= 1'b0;
            end
            WrDrain: if (wr_empty) wr_state_q <= WrSink;
            WrSink:  if (s_axi_wvalid && s_axi_wlast) wr_state_q <= WrBresp;
            WrBresp: if (s_axi_bready) wr_state_q <= WrIdle;
            default: wr_state_q <= WrIdle;
         endcase
      end
   end

   assign aw_fwd     = m_axi_awvalid & m_axi_awready;
   assign w_fwd_last = m_axi_wvalid & m_axi_wready & s_axi_wlast;
   assign err_sum    = {1'b0, err_q} + 9'(ar_reject) + 9'(aw_reject);

   always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) begin
         w_owed_q <= '0;
         err_q    <= '0;
      end else begin
         w_owed_q <= w_owed_q + OwedW'(aw_fwd) - OwedW'(w_fwd_last);
         err_q    <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end

   assign err_count = err_q;

`else

   logic unused_empty;
   assign unused_empty = rd_empty ^ wr_empty;

   assign m_axi_arvalid = run & s_axi_arvalid & ~rd_full;
   assign s_axi_arready = run & m_axi_arready & ~rd_full;
   assign m_axi_awvalid = run & s_axi_awvalid & ~wr_full;
   assign s_axi_awready = run & m_axi_awready & ~wr_full;

   assign m_axi_wvalid = run & s_axi_wvalid;
   assign s_axi_wready = run & m_axi_wready;

   assign s_axi_rvalid = run & m_axi_rvalid;
   assign s_axi_rid    = m_axi_rid;
   assign s_axi_rdata  = m_axi_rdata;
   assign s_axi_rresp  = m_axi_rresp;
   assign s_axi_rlast  = m_axi_rlast;
   assign m_axi_rready = run & s_axi_rready;

   assign s_axi_bvalid = run & m_axi_bvalid;
   assign s_axi_bid    = m_axi_bid;
   assign s_axi_bresp  = m_axi_bresp;
   assign m_axi_bready = run & s_axi_bready;

   assign err_count = 8'h00;

`endif

endmodule
